// File: rtl/seq_mem_loader_pkg.sv
// Shared definitions for the sequencer program-memory loader.
// The read side imports this package too, so both sides agree on word sizing.
package seq_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_CHECK,
        ST_DATA
    } loader_state_t;

    localparam int LEN_BYTES = 2;

    function automatic int bytes_per_word(int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/seq_mem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB-first and
// flags the byte that completes a word, presenting the full word alongside it.
module byte_packer #(
    parameter int DATA_WIDTH = 13,
    parameter int BPW        = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clr,
    input  logic                  i_vld,
    input  logic [7:0]            i_byte,
    output logic                  o_word_valid,
    output logic [DATA_WIDTH-1:0] o_word
);
    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_last;

    // Older bytes fall off the top, which discards bits above DATA_WIDTH.
    assign o_word       = DATA_WIDTH'({r_shift, i_byte});
    assign w_last       = (r_cnt == CW'(BPW - 1));
    assign o_word_valid = i_vld && w_last;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
        end else if (i_vld) begin
            r_shift <= o_word;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mem_loader.sv
// Unpacks a framed byte stream (16-bit word count, then big-endian words)
// into sequential writes on the sequencer program-memory write port.
module seq_mem_loader
    import seq_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int          BPW   = bytes_per_word(DATA_WIDTH);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    loader_state_t         r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_len;
    logic [15:0]           r_wcnt;

    logic                  w_accept;
    logic                  w_pack_vld;
    logic                  w_pack_clr;
    logic                  w_word_valid;
    logic [DATA_WIDTH-1:0] w_word;

    // Abort outranks a byte offered in the same cycle.
    assign w_accept   = s_valid_i && r_ready && !abort_i;
    assign w_pack_vld = w_accept && (r_state == ST_DATA);
    assign w_pack_clr = (r_state == ST_IDLE) && start_i;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BPW        (BPW)
    ) u_packer (
        .i_clk        (clk_i),
        .i_rstn       (rstn_i),
        .i_clr        (w_pack_clr),
        .i_vld        (w_pack_vld),
        .i_byte       (s_data_i),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_wcnt    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start_i) begin
                    r_state <= ST_LEN_HI;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b1;
                    r_err   <= 1'b0;
                    r_addr  <= '0;
                    r_wcnt  <= '0;
                end
            end else if (abort_i) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_LEN_HI: if (w_accept) begin
                        r_len[15:8] <= s_data_i;
                        r_state     <= ST_LEN_LO;
                    end
                    ST_LEN_LO: if (w_accept) begin
                        r_len[7:0] <= s_data_i;
                        r_state    <= ST_CHECK;
                        r_ready    <= 1'b0;
                    end
                    ST_CHECK: begin
                        // Rejecting oversize counts here is what keeps r_addr from wrapping.
                        if (r_len == 16'd0 || {1'b0, r_len} > DEPTH) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                            r_ready <= 1'b1;
                        end
                    end
                    ST_DATA: if (w_word_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_word;
                        r_addr    <= r_addr + 1'b1;
                        r_wcnt    <= r_wcnt + 16'd1;
                        if (r_wcnt == r_len - 16'd1) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_ready_o = r_ready;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;

endmodule

// File: tb/tb_seq_mem_loader.sv
// Randomized frame-level bench for seq_mem_loader: expected writes come from
// the frame bytes themselves (count header, big-endian words, masked to width).
module tb_seq_mem_loader;
    localparam int AW  = 8;
    localparam int DW  = 13;
    localparam int BPW = (DW + 7) / 8;
    localparam longint MASK = (64'd1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [7:0]    s_data_i = 8'd0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int            words;

    always #5 clk = ~clk;

    seq_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, s_ready_o, 0);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_addr"}, wr_addr_o, 0);
        chk({tag, "_data"}, wr_data_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    // Called shortly after a rising edge while the loader is idle.
    task automatic do_start(input bit with_abort);
        start_i = 1'b1;
        abort_i = with_abort;
        @(posedge clk); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_ready", s_ready_o, 1);
        chk("start_err_clr", err_o, 0);
    endtask

    // kill_at >= 0: after that many data bytes, abort (or reset if use_rst).
    task automatic run_frame(input int n, input int pct, input int kill_at,
                             input bit use_rst, input bit poke_start, output int nw);
        byte unsigned q[$];
        int     i, guard;
        longint w;
        bit     rdy, acc, kill, ewr, legal;
        legal = (n >= 1 && n <= (1 << AW));
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (legal)
            for (int k = 0; k < n * BPW; k++) q.push_back(8'($urandom));
        i = 0; guard = 0; w = 0; nw = 0;
        while (i < q.size() && guard < 5000) begin
            guard++;
            kill = (kill_at >= 0) && (i == 2 + kill_at);
            s_valid_i = kill ? 1'b1 : ($urandom_range(99) < pct);
            s_data_i  = q[i];
            abort_i   = kill && !use_rst;
            rstn_i    = !(kill && use_rst);
            start_i   = poke_start && (i == 3);
            @(negedge clk);
            rdy = s_ready_o;
            acc = s_valid_i && rdy && !kill;
            @(posedge clk); #1;
            s_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0; rstn_i = 1'b1;
            if (kill && use_rst) begin
                chk_reset_vals("midrst");
                last_addr = '0; last_data = '0;
                break;
            end
            ewr = 1'b0;
            if (acc) begin
                if (i >= 2) begin
                    w = (w << 8) | longint'(q[i]);
                    if (((i - 1) % BPW) == 0) ewr = 1'b1;
                end
                i++;
            end
            chk("wr_en", wr_en_o, ewr);
            if (ewr) begin
                chk("wr_addr", wr_addr_o, nw);
                chk("wr_data", wr_data_o, 32'(w & MASK));
                last_addr = AW'(nw);
                last_data = DW'(w & MASK);
                nw++; w = 0;
                chk("done", done_o, nw == n);
                chk("busy_at_write", busy_o, nw != n);
            end else begin
                chk("addr_hold", wr_addr_o, last_addr);
                chk("data_hold", wr_data_o, last_data);
                chk("no_done", done_o, 0);
            end
            if (kill) begin
                chk("abort_busy", busy_o, 0);
                chk("abort_err", err_o, 1);
                break;
            end
        end
        if (guard >= 5000) chk("frame_timeout", i, q.size());
        if (kill_at < 0) begin
            if (!legal) begin
                chk("check_err_wait", err_o, 0);
                chk("check_busy", busy_o, 1);
                @(posedge clk); #1;
                chk("len_err", err_o, 1);
                chk("len_busy", busy_o, 0);
                chk("len_no_wr", wr_en_o, 0);
            end else begin
                chk("frame_words", nw, n);
                chk("frame_err", err_o, 0);
                @(posedge clk); #1;
                chk("done_pulse_end", done_o, 0);
                chk("wr_en_end", wr_en_o, 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rstn_i = 1'b1;

        do_start(0); run_frame(3, 100, -1, 0, 0, words);
        do_start(0); run_frame(0, 100, -1, 0, 0, words);
        chk("n0_writes", words, 0);
        do_start(1); run_frame(257, 100, -1, 0, 0, words);
        chk("n257_writes", words, 0);
        do_start(0); run_frame(256, 100, -1, 0, 0, words);
        chk("n256_last_addr", last_addr, 255);
        do_start(0); run_frame(4, 50, -1, 0, 0, words);
        do_start(0); run_frame(4, 100, 3, 0, 1, words);
        chk("abort_writes", words, 1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_abort_done", done_o, 0);
            chk("post_abort_err", err_o, 1);
        end
        do_start(0); run_frame(4, 100, 1, 1, 0, words);
        chk("rst_writes", words, 0);
        do_start(0); run_frame(4, 70, -1, 0, 0, words);
        for (int r = 0; r < 6; r++) begin
            do_start(0);
            run_frame($urandom_range(1, 20), $urandom_range(30, 100), -1, 0, 0, words);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
